lieat_idu_ibuf: RTL and testbench

Parametrised instruction buffer between the IFU fetch output and the `lieat` decoder. It queues up to `DEPTH` fetched instructions with their PC, predicted-taken bit and fetch-fault bit. Fetch and decode are decoupled by valid/ready handshakes on both sides. An optional empty-bypass mode passes a fetch straight to decode in the same cycle. A pipeline flush discards everything queued.

---
 rtl/lieat_idu_ibuf_if.sv | 30 +++
 rtl/lieat_idu_ibuf.sv | 86 ++++++++
 tb/tb_lieat_idu_ibuf.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lieat_idu_ibuf_if.sv
// Fetch-side and decode-side valid/ready handshake bundle of the lieat instruction buffer.
// The buffer itself uses the slave view; the fetch/decode environment uses master.
interface lieat_idu_ibuf_if #(
    parameter int XLEN = 32,
    parameter int PC_W = XLEN
);
    logic            if_valid;
    logic            if_ready;
    logic [PC_W-1:0] if_pc;
    logic [XLEN-1:0] if_inst;
    logic            if_prdt_taken;
    logic            if_err;

    logic            id_valid;
    logic            id_ready;
    logic [PC_W-1:0] id_pc;
    logic [XLEN-1:0] id_inst;
    logic            id_prdt_taken;
    logic            id_err;

    modport slave (
        input  if_valid, if_pc, if_inst, if_prdt_taken, if_err, id_ready,
        output if_ready, id_valid, id_pc, id_inst, id_prdt_taken, id_err
    );

    modport master (
        output if_valid, if_pc, if_inst, if_prdt_taken, if_err, id_ready,
        input  if_ready, id_valid, id_pc, id_inst, id_prdt_taken, id_err
    );
endinterface

// File: rtl/lieat_idu_ibuf.sv
// Instruction buffer between IFU fetch and the lieat decoder: circular queue of
// {pc, inst, prdt_taken, err} with wrap-bit pointers, optional empty bypass and flush.
module lieat_idu_ibuf #(
    parameter int DEPTH  = 4,
    parameter int XLEN   = 32,
    parameter int PC_W   = XLEN,
    parameter int BYPASS = 1,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    lieat_idu_ibuf_if.slave  ibus,
    output logic [CNT_W-1:0] ibuf_cnt
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [PC_W-1:0]  pc_mem    [DEPTH];
    logic [XLEN-1:0]  inst_mem  [DEPTH];
    logic             taken_mem [DEPTH];
    logic             err_mem   [DEPTH];

    logic [CNT_W-1:0] wr_ptr;
    logic [CNT_W-1:0] rd_ptr;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic             empty;
    logic             full;
    logic             bypass_path;
    logic             push;
    logic             pop;

    assign wr_idx      = wr_ptr[IDX_W-1:0];
    assign rd_idx      = rd_ptr[IDX_W-1:0];
    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (wr_ptr[CNT_W-1] != rd_ptr[CNT_W-1]) && (wr_idx == rd_idx);
    assign bypass_path = (BYPASS != 0) && empty;
    assign ibuf_cnt    = wr_ptr - rd_ptr;

    // if_ready deliberately ignores id_ready so a full buffer never depends on decode timing.
    assign ibus.if_ready = ~full & ~flush;

    // A bypassed word that decode takes in the same cycle must not also be stored.
    assign push = ibus.if_valid & ibus.if_ready & ~(bypass_path & ibus.id_ready);
    assign pop  = ibus.id_valid & ibus.id_ready & ~empty;

    always_comb begin
        ibus.id_valid      = 1'b0;
        ibus.id_pc         = pc_mem[rd_idx];
        ibus.id_inst       = inst_mem[rd_idx];
        ibus.id_prdt_taken = taken_mem[rd_idx];
        ibus.id_err        = err_mem[rd_idx];
        if (!empty) begin
            ibus.id_valid = ~flush;
        end else if (bypass_path) begin
            ibus.id_valid      = ibus.if_valid & ~flush;
            ibus.id_pc         = ibus.if_pc;
            ibus.id_inst       = ibus.if_inst;
            ibus.id_prdt_taken = ibus.if_prdt_taken;
            ibus.id_err        = ibus.if_err;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + CNT_W'(1);
            if (pop)  rd_ptr <= rd_ptr + CNT_W'(1);
        end
    end

    // Payload storage carries no reset; only the pointers decide what is valid.
    always_ff @(posedge clock) begin
        if (push) begin
            pc_mem[wr_idx]    <= ibus.if_pc;
            inst_mem[wr_idx]  <= ibus.if_inst;
            taken_mem[wr_idx] <= ibus.if_prdt_taken;
            err_mem[wr_idx]   <= ibus.if_err;
        end
    end
endmodule

// File: tb/tb_lieat_idu_ibuf.sv
// Bench for lieat_idu_ibuf: a BYPASS=0 and a BYPASS=1 instance share stimulus and are
// checked against a queue model plus constant vectors and hand-written corner sequences.
module tb_lieat_idu_ibuf;
    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
    localparam int CNT_W = 3;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        taken;
        logic        err;
    } entry_t;

    typedef struct {
        logic        fl;
        logic        v;
        logic [31:0] pc;
        logic        rdy;
        logic        exp_ir;
        logic        exp_iv;
        logic [31:0] exp_pc;
        logic [2:0]  exp_cnt;
    } vec_t;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             drv_flush = 1'b0;
    logic             drv_valid = 1'b0;
    logic [31:0]      drv_pc = '0;
    logic [31:0]      drv_inst = '0;
    logic             drv_taken = 1'b0;
    logic             drv_err = 1'b0;
    logic             drv_ready = 1'b0;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    int tests_run = 0;
    int tests_failed = 0;

    entry_t q0[$];
    entry_t q1[$];
    vec_t   vecs[$];

    lieat_idu_ibuf_if #(.XLEN(XLEN), .PC_W(XLEN)) bus0 ();
    lieat_idu_ibuf_if #(.XLEN(XLEN), .PC_W(XLEN)) bus1 ();

    assign bus0.if_valid      = drv_valid;
    assign bus0.if_pc         = drv_pc;
    assign bus0.if_inst       = drv_inst;
    assign bus0.if_prdt_taken = drv_taken;
    assign bus0.if_err        = drv_err;
    assign bus0.id_ready      = drv_ready;
    assign bus1.if_valid      = drv_valid;
    assign bus1.if_pc         = drv_pc;
    assign bus1.if_inst       = drv_inst;
    assign bus1.if_prdt_taken = drv_taken;
    assign bus1.if_err        = drv_err;
    assign bus1.id_ready      = drv_ready;

    lieat_idu_ibuf #(.DEPTH(DEPTH), .XLEN(XLEN), .PC_W(XLEN), .BYPASS(0), .CNT_W(CNT_W)) dut0 (
        .clock    (clock),
        .reset    (reset),
        .flush    (drv_flush),
        .ibus     (bus0),
        .ibuf_cnt (cnt0)
    );

    lieat_idu_ibuf #(.DEPTH(DEPTH), .XLEN(XLEN), .PC_W(XLEN), .BYPASS(1), .CNT_W(CNT_W)) dut1 (
        .clock    (clock),
        .reset    (reset),
        .flush    (drv_flush),
        .ibus     (bus1),
        .ibuf_cnt (cnt1)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Model view: the buffer is an ordered list; decode sees its head, or the fetch word when bypassing an empty list.
    task automatic checkModel(input int b);
        entry_t      q[$];
        logic        a_ir, a_iv, a_tk, a_er, e_iv;
        logic [31:0] a_pc, a_inst;
        logic [2:0]  a_cnt;
        entry_t      head;
        string       tag;
        if (b == 0) begin
            q = q0; tag = "byp0";
            a_ir = bus0.if_ready; a_iv = bus0.id_valid; a_pc = bus0.id_pc;
            a_inst = bus0.id_inst; a_tk = bus0.id_prdt_taken; a_er = bus0.id_err; a_cnt = cnt0;
        end else begin
            q = q1; tag = "byp1";
            a_ir = bus1.if_ready; a_iv = bus1.id_valid; a_pc = bus1.id_pc;
            a_inst = bus1.id_inst; a_tk = bus1.id_prdt_taken; a_er = bus1.id_err; a_cnt = cnt1;
        end
        e_iv = !drv_flush && (q.size() > 0 || (b == 1 && drv_valid));
        checkOutput({tag, " if_ready"}, 64'(a_ir), 64'((q.size() < DEPTH) && !drv_flush));
        checkOutput({tag, " id_valid"}, 64'(a_iv), 64'(e_iv));
        checkOutput({tag, " ibuf_cnt"}, 64'(a_cnt), 64'(q.size()));
        if (e_iv) begin
            if (q.size() > 0) begin
                head = q[0];
            end else begin
                head.pc = drv_pc; head.inst = drv_inst; head.taken = drv_taken; head.err = drv_err;
            end
            checkOutput({tag, " id_pc"}, 64'(a_pc), 64'(head.pc));
            checkOutput({tag, " id_inst"}, 64'(a_inst), 64'(head.inst));
            checkOutput({tag, " id_prdt_taken"}, 64'(a_tk), 64'(head.taken));
            checkOutput({tag, " id_err"}, 64'(a_er), 64'(head.err));
        end
    endtask

    task automatic updateModel(input int b);
        entry_t q[$];
        entry_t e;
        int     sz;
        logic   fire_in, fire_out;
        if (b == 0) q = q0; else q = q1;
        sz = q.size();
        if (drv_flush) begin
            q.delete();
        end else begin
            fire_out = drv_ready && (sz > 0 || (b == 1 && drv_valid));
            fire_in  = drv_valid && (sz < DEPTH);
            if (fire_out && sz > 0) void'(q.pop_front());
            if (fire_in && !(sz == 0 && b == 1 && drv_ready)) begin
                e.pc = drv_pc; e.inst = drv_inst; e.taken = drv_taken; e.err = drv_err;
                q.push_back(e);
            end
        end
        if (b == 0) q0 = q; else q1 = q;
    endtask

    task automatic applyStimulus(input logic fl, input logic v, input logic [31:0] pc,
                                 input logic [31:0] inst, input logic tk, input logic er,
                                 input logic rdy);
        drv_flush = fl; drv_valid = v; drv_pc = pc; drv_inst = inst;
        drv_taken = tk; drv_err = er; drv_ready = rdy;
        #4;
        checkModel(0);
        checkModel(1);
    endtask

    task automatic finishCycle();
        @(posedge clock);
        updateModel(0);
        updateModel(1);
        #1;
    endtask

    function automatic void addVec(input logic fl, input logic v, input logic [31:0] pc,
                                   input logic rdy, input logic ir, input logic iv,
                                   input logic [31:0] epc, input logic [2:0] cnt);
        vec_t r;
        r.fl = fl; r.v = v; r.pc = pc; r.rdy = rdy;
        r.exp_ir = ir; r.exp_iv = iv; r.exp_pc = epc; r.exp_cnt = cnt;
        vecs.push_back(r);
    endfunction

    initial begin
        vec_t v;
        logic fl, vl, rd;

        // Constant expectations below describe the BYPASS=0 instance.
        addVec(1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 32'h0, 3'd0);
        addVec(1'b0, 1'b1, 32'h8000_0004, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 3'd1);
        addVec(1'b0, 1'b1, 32'h8000_0008, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 3'd2);
        addVec(1'b0, 1'b1, 32'h8000_000C, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 3'd3);
        addVec(1'b0, 1'b1, 32'h8000_0010, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 3'd4);
        addVec(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h8000_0000, 3'd4);
        addVec(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h8000_0004, 3'd3);
        addVec(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h8000_0008, 3'd2);
        addVec(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h8000_000C, 3'd1);
        addVec(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 3'd0);
        addVec(1'b0, 1'b1, 32'h200, 1'b0, 1'b1, 1'b0, 32'h0, 3'd0);
        addVec(1'b0, 1'b1, 32'h204, 1'b0, 1'b1, 1'b1, 32'h200, 3'd1);
        for (int k = 0; k < 10; k++)
            addVec(1'b0, 1'b1, 32'h208 + 32'(4 * k), 1'b1, 1'b1, 1'b1, 32'h200 + 32'(4 * k), 3'd2);
        addVec(1'b0, 1'b1, 32'h230, 1'b0, 1'b1, 1'b1, 32'h228, 3'd2);
        addVec(1'b1, 1'b1, 32'h234, 1'b1, 1'b0, 1'b0, 32'h0, 3'd3);
        addVec(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 3'd0);
        addVec(1'b0, 1'b1, 32'h300, 1'b1, 1'b1, 1'b0, 32'h0, 3'd0);
        addVec(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h300, 3'd1);
        addVec(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 3'd0);

        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        foreach (vecs[i]) begin
            v = vecs[i];
            applyStimulus(v.fl, v.v, v.pc, ~v.pc, v.pc[3], v.pc[2], v.rdy);
            checkOutput($sformatf("vec%0d if_ready", i), 64'(bus0.if_ready), 64'(v.exp_ir));
            checkOutput($sformatf("vec%0d id_valid", i), 64'(bus0.id_valid), 64'(v.exp_iv));
            checkOutput($sformatf("vec%0d ibuf_cnt", i), 64'(cnt0), 64'(v.exp_cnt));
            if (v.exp_iv)
                checkOutput($sformatf("vec%0d id_pc", i), 64'(bus0.id_pc), 64'(v.exp_pc));
            finishCycle();
        end

        // Same-cycle bypass on the empty BYPASS=1 instance.
        applyStimulus(1'b0, 1'b1, 32'h100, 32'h0000_0013, 1'b0, 1'b1, 1'b1);
        checkOutput("bypass id_valid", 64'(bus1.id_valid), 64'(1));
        checkOutput("bypass id_inst", 64'(bus1.id_inst), 64'h13);
        checkOutput("bypass id_pc", 64'(bus1.id_pc), 64'h100);
        checkOutput("bypass id_err", 64'(bus1.id_err), 64'(1));
        checkOutput("bypass ibuf_cnt", 64'(cnt1), 64'(0));
        finishCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        checkOutput("bypass cnt after", 64'(cnt1), 64'(0));
        checkOutput("bypass valid after", 64'(bus1.id_valid), 64'(0));
        finishCycle();

        // Asynchronous reset between edges with two entries stored.
        applyStimulus(1'b0, 1'b1, 32'h400, 32'h11, 1'b1, 1'b0, 1'b0);
        finishCycle();
        applyStimulus(1'b0, 1'b1, 32'h404, 32'h22, 1'b0, 1'b0, 1'b0);
        finishCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("prereset cnt0", 64'(cnt0), 64'(2));
        checkOutput("prereset cnt1", 64'(cnt1), 64'(2));
        #2 reset = 1'b1;
        #1;
        checkOutput("async reset cnt0", 64'(cnt0), 64'(0));
        checkOutput("async reset cnt1", 64'(cnt1), 64'(0));
        checkOutput("async reset id_valid0", 64'(bus0.id_valid), 64'(0));
        checkOutput("async reset id_valid1", 64'(bus1.id_valid), 64'(0));
        checkOutput("async reset if_ready0", 64'(bus0.if_ready), 64'(1));
        checkOutput("async reset if_ready1", 64'(bus1.if_ready), 64'(1));
        q0.delete();
        q1.delete();
        #1 reset = 1'b0;
        finishCycle();

        // Random traffic: alternate a slow-decode phase (fills up) with a fast-decode phase.
        for (int n = 0; n < 600; n++) begin
            fl = ($urandom_range(0, 24) == 0);
            vl = ($urandom_range(0, 3) != 0);
            rd = ($urandom_range(0, 9) < (((n / 100) % 2 == 0) ? 3 : 8));
            applyStimulus(fl, vl, $urandom, $urandom, $urandom_range(0, 1) == 1,
                          $urandom_range(0, 1) == 1, rd);
            finishCycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
